// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register: owns the PC, runs a one-outstanding
// imem handshake and pre-decodes immediate_sel. Optional perf counters: FETCH_PERF_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_offset,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [23:0] immediate_24,
  output logic [1:0]  immediate_sel,
  output logic [1:0]  dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [15:0] flush_count
`endif
);

  // Handshake: imem_req is a one-cycle pulse in REQ with imem_addr=pc; the single
  // response is taken on any later cycle where imem_valid=1 while in WAIT.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [1:0]  imm_sel_q, imm_sel_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;

  logic        load_id;
  logic [31:0] load_word;
  logic [31:0] load_pc;
  logic [31:0] br_target;
  logic        slot_free;

  function automatic logic [1:0] predecode(input logic [31:0] i);
    if (i[27:25] == 3'b001)      return 2'd0;
    else if (i[27:26] == 2'b01)  return 2'd1;
    else if (i[27:25] == 3'b101) return 2'd2;
    else                         return 2'd3;
  endfunction

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    discard_d    = discard_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    imm_sel_d    = imm_sel_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    load_id      = 1'b0;
    load_word    = imem_rdata;
    load_pc      = pc_q;
    br_target    = br_pc + 32'd8 + br_offset;
    slot_free    = !id_valid_q || !id_stall;

    if (br_taken) begin
      pc_d       = br_target;
      id_valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          // The old-PC request is already on the bus; its response must be dropped.
          discard_d = 1'b1;
          state_d   = S_WAIT;
        end
        S_WAIT: begin
          if (imem_valid) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end
        end
        default: begin
          discard_d = 1'b0;
          state_d   = S_REQ;
        end
      endcase
    end else begin
      if (!id_stall) id_valid_d = 1'b0;
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ:  state_d = S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else if (slot_free) begin
              load_id = 1'b1;
              pc_d    = pc_q + PC_STEP;
              state_d = S_REQ;
            end else begin
              hold_instr_d = imem_rdata;
              hold_pc_d    = pc_q;
              pc_d         = pc_q + PC_STEP;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!id_stall) begin
            load_id   = 1'b1;
            load_word = hold_instr_q;
            load_pc   = hold_pc_q;
            state_d   = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (load_id) begin
        id_valid_d = 1'b1;
        id_instr_d = load_word;
        id_pc_d    = load_pc;
        imm_sel_d  = predecode(load_word);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      discard_q    <= 1'b0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= 32'd0;
      id_pc_q      <= 32'd0;
      imm_sel_q    <= 2'd3;
      hold_instr_q <= 32'd0;
      hold_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      imm_sel_q    <= imm_sel_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  assign imem_req      = (state_q == S_REQ);
  assign imem_addr     = (state_q == S_REQ) ? pc_q : 32'd0;
  assign id_valid      = id_valid_q;
  assign id_instr      = id_instr_q;
  assign id_pc         = id_pc_q;
  assign immediate_24  = id_instr_q[23:0];
  assign immediate_sel = imm_sel_q;
  assign dbg_state     = state_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [15:0] flush_count_q, flush_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    flush_count_d = flush_count_q;
    if (load_id) fetch_count_d = fetch_count_q + 32'd1;
    if (br_taken && (flush_count_q != 16'hFFFF)) flush_count_d = flush_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= 32'd0;
      flush_count_q <= 16'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural imem with programmable latency,
// expected ID-register loads queued per scenario and popped as the DUT loads them.
module tb_fetch_stage;

  localparam int W = 66;  // {id_pc, id_instr, immediate_sel}
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [23:0] immediate_24;
  logic [1:0]  immediate_sel;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
`endif

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  int          mem_lat;
  int          mem_mode;  // 0: data = address, 1: data = fixed_word
  logic [31:0] fixed_word;
  logic        pend;
  logic [31:0] paddr;
  int          cnt;
  logic        new_load;
  logic        pv, ps;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .br_taken(br_taken), .br_pc(br_pc), .br_offset(br_offset),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .immediate_24(immediate_24), .immediate_sel(immediate_sel),
    .dbg_state(dbg_state)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  // Instruction memory: answers a request mem_lat cycles after it is seen.
  initial begin
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
    pend = 1'b0;
    paddr = 32'd0;
    cnt = 0;
    forever begin
      @(posedge clk);
      if (imem_req === 1'b1) begin
        pend = 1'b1;
        paddr = imem_addr;
        cnt = mem_lat;
      end
      #1;
      imem_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          imem_valid = 1'b1;
          imem_rdata = (mem_mode == 0) ? paddr : fixed_word;
          pend = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    pv = id_valid;
    ps = id_stall;
    #2;
    new_load = (id_valid === 1'b1) && !(pv === 1'b1 && ps === 1'b1);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    br_taken = 1'b0;
    id_stall = 1'b0;
    mem_lat = 1;
    mem_mode = 0;
    step;
    step;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset;
    do_reset;
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_id_valid: got %b need 0", id_valid); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_imem_req: got %b need 0", imem_req); end
    vectors++; if (imem_addr !== 32'd0) begin miscompares++; $display("FAIL reset_imem_addr: got %h need 0", imem_addr); end
    vectors++; if (id_instr !== 32'd0) begin miscompares++; $display("FAIL reset_id_instr: got %h need 0", id_instr); end
    vectors++; if (id_pc !== 32'd0) begin miscompares++; $display("FAIL reset_id_pc: got %h need 0", id_pc); end
    vectors++; if (immediate_sel !== 2'd3) begin miscompares++; $display("FAIL reset_imm_sel: got %0d need 3", immediate_sel); end
    vectors++; if (dbg_state !== ST_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d need IDLE", dbg_state); end
    // Reset while a request is outstanding returns to IDLE.
    mem_lat = 3;
    step;
    step;
    vectors++; if (dbg_state !== ST_WAIT) begin miscompares++; $display("FAIL reset_pre_wait: got %0d need WAIT", dbg_state); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    vectors++; if (dbg_state !== ST_IDLE || imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_in_wait: state %0d req %b need IDLE/0", dbg_state, imem_req); end
  endtask

  task automatic test_free_run;
    logic [W-1:0] e;
    logic [31:0] exp_addr;
    logic seen, last_v;
    int guard;
    do_reset;
    for (int k = 0; k < 6; k++) exp_q.push_back({32'(k * 4), 32'(k * 4), 2'd3});
    exp_addr = 32'd0;
    seen = 1'b0;
    last_v = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      step;
      guard++;
      if (imem_req === 1'b1) begin
        vectors++;
        if (imem_addr !== exp_addr) begin miscompares++; $display("FAIL free_run_addr: got %h need %h", imem_addr, exp_addr); end
        exp_addr += 32'd4;
      end
      if (seen) begin
        vectors++;
        if (id_valid === last_v) begin miscompares++; $display("FAIL free_run_alternate: id_valid %b twice", id_valid); end
      end
      if (new_load) begin
        e = exp_q.pop_front();
        vectors++; if (id_pc !== e[65:34]) begin miscompares++; $display("FAIL free_run_pc: got %h need %h", id_pc, e[65:34]); end
        vectors++; if (id_instr !== e[33:2]) begin miscompares++; $display("FAIL free_run_instr: got %h need %h", id_instr, e[33:2]); end
        vectors++; if (immediate_sel !== e[1:0]) begin miscompares++; $display("FAIL free_run_sel: got %0d need %0d", immediate_sel, e[1:0]); end
        seen = 1'b1;
      end
      last_v = id_valid;
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL free_run_timeout: %0d loads missing, need 0", exp_q.size()); end
  endtask

  task automatic test_predecode;
    logic [W-1:0] e;
    logic [31:0] words[4];
    logic [1:0] sels[4];
    int guard;
    words = '{32'hE3A0_1005, 32'hE591_2004, 32'hEA00_0002, 32'hE081_2003};
    sels = '{2'd0, 2'd1, 2'd2, 2'd3};
    for (int n = 0; n < 4; n++) begin
      do_reset;
      mem_mode = 1;
      fixed_word = words[n];
      exp_q.push_back({32'h0, words[n], sels[n]});
      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
        step;
        guard++;
        if (new_load) begin
          e = exp_q.pop_front();
          vectors++; if (id_instr !== e[33:2]) begin miscompares++; $display("FAIL predecode_instr: got %h need %h", id_instr, e[33:2]); end
          vectors++; if (immediate_sel !== e[1:0]) begin miscompares++; $display("FAIL predecode_sel: word %h got %0d need %0d", e[33:2], immediate_sel, e[1:0]); end
          vectors++; if (immediate_24 !== e[25:2]) begin miscompares++; $display("FAIL predecode_imm24: got %h need %h", immediate_24, e[25:2]); end
        end
      end
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL predecode_timeout: word %h never loaded", words[n]); end
    end
  endtask

  task automatic test_stall;
    logic [W-1:0] e;
    int guard;
    do_reset;
    for (int k = 0; k < 3; k++) exp_q.push_back({32'(k * 4), 32'(k * 4), 2'd3});
    guard = 0;
    while (exp_q.size() == 3 && guard < 20) begin
      step;
      guard++;
      if (new_load) begin
        e = exp_q.pop_front();
        vectors++; if (id_pc !== e[65:34]) begin miscompares++; $display("FAIL stall_first_pc: got %h need %h", id_pc, e[65:34]); end
      end
    end
    id_stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step;
      vectors++;
      if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h0) begin
        miscompares++; $display("FAIL stall_frozen: v=%b pc=%h instr=%h need 1/0/0", id_valid, id_pc, id_instr);
      end
    end
    vectors++; if (dbg_state !== ST_HOLD) begin miscompares++; $display("FAIL stall_hold_state: got %0d need HOLD", dbg_state); end
    id_stall = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      step;
      guard++;
      if (new_load) begin
        e = exp_q.pop_front();
        vectors++; if (id_pc !== e[65:34]) begin miscompares++; $display("FAIL stall_release_pc: got %h need %h", id_pc, e[65:34]); end
        vectors++; if (id_instr !== e[33:2]) begin miscompares++; $display("FAIL stall_release_instr: got %h need %h", id_instr, e[33:2]); end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL stall_timeout: %0d loads missing", exp_q.size()); end
  endtask

  task automatic test_branch_wait;
    logic [W-1:0] e;
    logic req_checked;
    int guard;
    do_reset;
    mem_lat = 3;
    step;
    step;
    vectors++; if (dbg_state !== ST_WAIT) begin miscompares++; $display("FAIL br_wait_pre: got %0d need WAIT", dbg_state); end
    br_taken = 1'b1;
    br_pc = 32'h100;
    br_offset = 32'h10;
    exp_q.push_back({32'h118, 32'h118, 2'd3});
    step;
    br_taken = 1'b0;
    req_checked = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 30) begin
      step;
      guard++;
      if (imem_req === 1'b1 && !req_checked) begin
        vectors++;
        if (imem_addr !== 32'h118) begin miscompares++; $display("FAIL br_wait_addr: got %h need 00000118", imem_addr); end
        req_checked = 1'b1;
      end
      if (new_load) begin
        e = exp_q.pop_front();
        vectors++; if (id_pc !== e[65:34]) begin miscompares++; $display("FAIL br_wait_pc: got %h need %h", id_pc, e[65:34]); end
        vectors++; if (id_instr !== e[33:2]) begin miscompares++; $display("FAIL br_wait_instr: got %h need %h", id_instr, e[33:2]); end
      end else begin
        vectors++;
        if (id_valid !== 1'b0) begin miscompares++; $display("FAIL br_wait_bubble: id_valid %b need 0", id_valid); end
      end
    end
    vectors++; if (exp_q.size() != 0 || !req_checked) begin miscompares++; $display("FAIL br_wait_timeout: target word never loaded"); end
  endtask

  task automatic test_branch_same;
    logic [W-1:0] e;
    int guard;
`ifdef FETCH_PERF_EN
    logic [15:0] flush_before;
`endif
    do_reset;
    exp_q.push_back({32'h0, 32'h0, 2'd3});
    exp_q.push_back({32'h0, 32'h0, 2'd3});
    guard = 0;
    while (exp_q.size() == 2 && guard < 20) begin
      step;
      guard++;
      if (new_load) e = exp_q.pop_front();
    end
    step;
    vectors++; if (dbg_state !== ST_WAIT) begin miscompares++; $display("FAIL br_same_pre: got %0d need WAIT", dbg_state); end
`ifdef FETCH_PERF_EN
    flush_before = flush_count;
`endif
    br_taken = 1'b1;
    br_pc = 32'hFFFF_FFF8;
    br_offset = 32'h0;
    step;
    br_taken = 1'b0;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL br_same_wrap: req %b addr %h need 1/00000000", imem_req, imem_addr); end
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL br_same_flush: id_valid %b need 0", id_valid); end
`ifdef FETCH_PERF_EN
    vectors++; if (flush_count !== flush_before + 16'd1) begin miscompares++; $display("FAIL br_same_flush_count: got %0d need %0d", flush_count, flush_before + 16'd1); end
`endif
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      step;
      guard++;
      if (new_load) begin
        e = exp_q.pop_front();
        vectors++; if (id_pc !== e[65:34]) begin miscompares++; $display("FAIL br_same_pc: got %h need %h", id_pc, e[65:34]); end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL br_same_timeout: target word never loaded"); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] e;
    logic [31:0] prev_pc;
    int guard;
    do_reset;
    for (int k = 0; k < 12; k++) exp_q.push_back({32'(k * 4), 32'(k * 4), 2'd3});
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      prev_pc = id_pc;
      step;
      guard++;
      if (pv === 1'b1 && ps === 1'b1) begin
        vectors++;
        if (id_valid !== 1'b1 || id_pc !== prev_pc) begin miscompares++; $display("FAIL b2b_hold: v=%b pc=%h need 1/%h", id_valid, id_pc, prev_pc); end
      end
      if (new_load) begin
        e = exp_q.pop_front();
        vectors++; if (id_pc !== e[65:34]) begin miscompares++; $display("FAIL b2b_pc: got %h need %h", id_pc, e[65:34]); end
        vectors++; if (id_instr !== e[33:2]) begin miscompares++; $display("FAIL b2b_instr: got %h need %h", id_instr, e[33:2]); end
      end
      id_stall = 1'($urandom_range(0, 1));
      mem_lat = $urandom_range(1, 3);
    end
    id_stall = 1'b0;
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_timeout: %0d loads missing", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    br_taken = 1'b0;
    br_pc = 32'd0;
    br_offset = 32'd0;
    id_stall = 1'b0;
    mem_lat = 1;
    mem_mode = 0;
    fixed_word = 32'd0;
    new_load = 1'b0;
    pv = 1'b0;
    ps = 1'b0;
    test_reset;
    test_free_run;
    test_predecode;
    test_stall;
    test_branch_wait;
    test_branch_same;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
